// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream_demux2 1-to-2 packet demultiplexer.
//   demux_state_e : routing FSM state (IDLE between packets, PKT0/PKT1 while a
//                   packet is bound to channel 0/1).
//   CH0, CH1      : channel identifiers, matching the value of s_sel.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT0 = 2'd1,
        PKT1 = 2'd2
    } demux_state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry valid/ready output register carrying a payload and a last flag.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load        : write load_data/load_last into the register this edge
//   load_data   : payload to capture
//   load_last   : last flag to capture
//   can_accept  : register is empty or is being drained this cycle
//   valid/ready : downstream handshake; data/last held while valid && !ready
//   data, last  : registered payload and last flag
module stream_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              can_accept,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    // A drain and a refill in the same cycle replace the entry, so a full
    // register whose consumer is ready can still take a new beat.
    assign can_accept = ~valid | ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux2.sv
// 1-to-2 packet stream demultiplexer with a one-entry register per channel.
// The destination is taken from s_sel on the first beat of a packet and held
// until its last beat; beats then arrive on that channel one cycle later.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both 1.
// A producer holding valid must keep data/last stable until the transfer;
// ready never depends on valid on the same interface.
//
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last    : input stream
//   s_sel                            : destination, sampled on first beats only
//   m0_valid/m0_ready/m0_data/m0_last: channel 0 output stream
//   m1_valid/m1_ready/m1_data/m1_last: channel 1 output stream
//   state                            : current routing FSM state (debug)
//   pkt_cnt0, pkt_cnt1               : completed-packet counters, present only
//                                      when STREAM_DEMUX_CNT_EN is defined
// Build option: define STREAM_DEMUX_CNT_EN to add the packet counters.
module stream_demux2
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef STREAM_DEMUX_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_sel,
    output logic              m0_valid,
    input  logic              m0_ready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m0_last,
    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [DATA_W-1:0] m1_data,
    output logic              m1_last,
    output demux_state_e      state
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

    logic         tgt;
    logic         accept;
    logic         load0;
    logic         load1;
    logic         can0;
    logic         can1;
    demux_state_e state_next;

    // Mid-packet the route is fixed; only a first beat looks at s_sel.
    always_comb begin
        tgt = s_sel;
        case (state)
            PKT0:    tgt = CH0;
            PKT1:    tgt = CH1;
            default: tgt = s_sel;
        endcase
    end

    // Head-of-line: only the target channel's space gates the input, even if
    // the other channel is free.
    assign s_ready = (tgt == CH1) ? can1 : can0;
    assign accept  = s_valid & s_ready;
    assign load0   = accept & (tgt == CH0);
    assign load1   = accept & (tgt == CH1);

    always_comb begin
        state_next = state;
        if (accept) begin
            if (s_last) begin
                state_next = IDLE;
            end else begin
                state_next = (tgt == CH1) ? PKT1 : PKT0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    stream_out_reg #(.DATA_W(DATA_W)) u_out0 (
        .clk        (clk),
        .rst        (rst),
        .load       (load0),
        .load_data  (s_data),
        .load_last  (s_last),
        .can_accept (can0),
        .valid      (m0_valid),
        .ready      (m0_ready),
        .data       (m0_data),
        .last       (m0_last)
    );

    stream_out_reg #(.DATA_W(DATA_W)) u_out1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load1),
        .load_data  (s_data),
        .load_last  (s_last),
        .can_accept (can1),
        .valid      (m1_valid),
        .ready      (m1_ready),
        .data       (m1_data),
        .last       (m1_last)
    );

`ifdef STREAM_DEMUX_CNT_EN
    // Packets are counted when their last beat enters, not when it leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (load0 && s_last) begin
                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            end
            if (load1 && s_last) begin
                pkt_cnt1 <= pkt_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule
